ram32x4_arbiter: RTL

Controller that shares one single-port synchronous 32x4 RAM (the `ram32x4` IP instance) between two requesters, A and B. Each requester can issue one read or write per cycle over a request/grant handshake. Conflicts are resolved by round-robin arbitration, and read data returns on a fixed-latency pipeline tagged per requester. The block sits between the board-level logic (switch/key front end, or any future client) and the RAM's `address`/`data`/`wren`/`q` pins, and all logic runs on the single system clock.

---
 rtl/ram32x4_arbiter_if.sv | 33 +++
 rtl/ram32x4_arbiter.sv | 121 ++++++++++++
 2 files changed

// File: rtl/ram32x4_arbiter_if.sv
// Requester-side bus of ram32x4_arbiter: two request/grant ports (A, B) plus tagged read return.
interface ram32x4_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 4
);
  logic                  a_req;
  logic                  a_we;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic                  a_gnt;
  logic                  a_rvalid;

  logic                  b_req;
  logic                  b_we;
  logic [ADDR_WIDTH-1:0] b_addr;
  logic [DATA_WIDTH-1:0] b_wdata;
  logic                  b_gnt;
  logic                  b_rvalid;

  logic [DATA_WIDTH-1:0] rdata;

  modport master (
    output a_req, a_we, a_addr, a_wdata,
    output b_req, b_we, b_addr, b_wdata,
    input  a_gnt, a_rvalid, b_gnt, b_rvalid, rdata
  );

  modport slave (
    input  a_req, a_we, a_addr, a_wdata,
    input  b_req, b_we, b_addr, b_wdata,
    output a_gnt, a_rvalid, b_gnt, b_rvalid, rdata
  );
endinterface

// File: rtl/ram32x4_arbiter.sv
// Round-robin arbiter sharing one single-port synchronous RAM between requesters A and B.
// Optional zero-fill sweep after reset: define RAM32X4_ARBITER_INIT_EN.
module ram32x4_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 5,
  parameter int unsigned DATA_WIDTH   = 4,
  parameter int unsigned READ_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  reset_n,
  ram32x4_arbiter_if.slave      bus,
  output logic [ADDR_WIDTH-1:0] ram_address,
  output logic [DATA_WIDTH-1:0] ram_data,
  output logic                  ram_wren,
  input  logic [DATA_WIDTH-1:0] ram_q,
  output logic                  busy
);
  localparam int unsigned PIPE_DEPTH = READ_LATENCY + 1;

  logic                  r_last;
  logic [ADDR_WIDTH-1:0] r_ram_address;
  logic [DATA_WIDTH-1:0] r_ram_data;
  logic                  r_ram_wren;
  logic [PIPE_DEPTH-1:0] r_tag_vld;
  logic [PIPE_DEPTH-1:0] r_tag_id;

  logic                  w_run;
  logic                  w_gnt_a;
  logic                  w_gnt_b;
  logic                  w_gnt;
  logic                  w_sel_we;
  logic [ADDR_WIDTH-1:0] w_sel_addr;
  logic [DATA_WIDTH-1:0] w_sel_wdata;

`ifdef RAM32X4_ARBITER_INIT_EN
  typedef enum logic {ST_INIT, ST_RUN} state_t;
  state_t                r_state;
  logic [ADDR_WIDTH-1:0] r_init_addr;

  assign w_run = (r_state == ST_RUN);
  assign busy  = (r_state == ST_INIT);
`else
  assign w_run = 1'b1;
  assign busy  = 1'b0;
`endif

  // Round-robin pick; r_last=1 means B was granted last, so A wins a tie.
  always_comb begin
    w_gnt_a = 1'b0;
    w_gnt_b = 1'b0;
    if (reset_n && w_run) begin
      if (bus.a_req && bus.b_req) begin
        w_gnt_a = r_last;
        w_gnt_b = ~r_last;
      end else begin
        w_gnt_a = bus.a_req;
        w_gnt_b = bus.b_req;
      end
    end
  end

  assign w_gnt = w_gnt_a | w_gnt_b;

  always_comb begin
    w_sel_we    = bus.a_we;
    w_sel_addr  = bus.a_addr;
    w_sel_wdata = bus.a_wdata;
    if (w_gnt_b) begin
      w_sel_we    = bus.b_we;
      w_sel_addr  = bus.b_addr;
      w_sel_wdata = bus.b_wdata;
    end
  end

  // Issue register to the RAM pins plus the {valid,id} read tag pipe.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_last        <= 1'b1;
      r_ram_address <= '0;
      r_ram_data    <= '0;
      r_ram_wren    <= 1'b0;
      r_tag_vld     <= '0;
      r_tag_id      <= '0;
`ifdef RAM32X4_ARBITER_INIT_EN
      r_state       <= ST_INIT;
      r_init_addr   <= '0;
`endif
    end else begin
      r_ram_wren <= 1'b0;
      r_tag_vld  <= {r_tag_vld[PIPE_DEPTH-2:0], w_gnt & ~w_sel_we};
      r_tag_id   <= {r_tag_id[PIPE_DEPTH-2:0], w_gnt_b};
      if (w_gnt) begin
        r_last        <= w_gnt_b;
        r_ram_address <= w_sel_addr;
        r_ram_data    <= w_sel_wdata;
        r_ram_wren    <= w_sel_we;
      end
`ifdef RAM32X4_ARBITER_INIT_EN
      // Zero-fill sweep, one word per cycle; no grants can occur meanwhile.
      if (r_state == ST_INIT) begin
        r_ram_address <= r_init_addr;
        r_ram_data    <= '0;
        r_ram_wren    <= 1'b1;
        r_init_addr   <= r_init_addr + ADDR_WIDTH'(1);
        if (r_init_addr == '1) begin
          r_state <= ST_RUN;
        end
      end
`endif
    end
  end

  assign bus.a_gnt    = w_gnt_a;
  assign bus.b_gnt    = w_gnt_b;
  assign bus.a_rvalid = r_tag_vld[PIPE_DEPTH-1] & ~r_tag_id[PIPE_DEPTH-1];
  assign bus.b_rvalid = r_tag_vld[PIPE_DEPTH-1] &  r_tag_id[PIPE_DEPTH-1];
  assign bus.rdata    = ram_q;

  assign ram_address = r_ram_address;
  assign ram_data    = r_ram_data;
  assign ram_wren    = r_ram_wren;
endmodule
